// File: rtl/timer_pkg.sv
// Shared types and default constants for the timer subsystem
// (countdown_timer and the stopwatch).
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

  localparam int TICK_DIV_DEF = 4;   // clk cycles per tick
  localparam int MS_MAX_DEF   = 10;  // top value of the ms digit
  localparam int CNT_W_DEF    = 10;  // width of the min / ms digits

endpackage

// File: rtl/tick_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while en, pulses tick on terminal
// count. clr wins over en; the count holds when en is low.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // Phase counter; wraps to 0 on the tick cycle
  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/countdown_timer.sv
// Programmable min:ms countdown timer with start/stop/load control.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: on reaching 0:0 the
// counters reload from the last loaded value and keep running.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int MS_MAX   = MS_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_min,
  input  logic [CNT_W-1:0] load_ms,
  input  logic             start,
  input  logic             stop,
  output logic [CNT_W-1:0] milicount,
  output logic [CNT_W-1:0] mincount,
  output logic             run_on,
  output logic             pause_on,
  output logic             expired,
  output logic             done
);

  localparam logic [CNT_W-1:0] MS_TOP = CNT_W'(MS_MAX);

  timer_state_e     state;
  logic [CNT_W-1:0] ms_q, min_q;
  logic             done_q;
  logic [CNT_W-1:0] ld_ms;
  logic             at_zero, last_step;
  logic             ps_clr, ps_en, tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [CNT_W-1:0] rl_ms, rl_min;
  logic             rl_nonzero;
  assign rl_nonzero = (rl_ms != '0) || (rl_min != '0);
`endif

  assign ld_ms     = (load_ms > MS_TOP) ? MS_TOP : load_ms;
  assign at_zero   = (ms_q == '0) && (min_q == '0);
  assign last_step = (min_q == '0) && (ms_q == CNT_W'(1));

  // Prescaler only advances in RUN and freezes on stop so a partial tick
  // survives a pause. Outside RUN/PAUSE it is parked at 0, so a start from
  // IDLE begins a full tick; a load from PAUSE also restarts the phase.
  // The tick cycle itself wraps the phase to 0, which covers auto-reload.
  assign ps_en  = (state == ST_RUN) && !stop;
  assign ps_clr = (state == ST_IDLE) || (state == ST_EXPIRED) ||
                  ((state == ST_PAUSE) && load);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (ps_clr),
    .en    (ps_en),
    .tick  (tick)
  );

  // Control FSM and min:ms counters; done is a one-cycle registered pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ms_q   <= '0;
      min_q  <= '0;
      done_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      rl_ms  <= '0;
      rl_min <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            ms_q  <= ld_ms;
            min_q <= load_min;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rl_ms  <= ld_ms;
            rl_min <= load_min;
`endif
          end else if (start && !stop) begin
            if (at_zero) begin
              state  <= ST_EXPIRED;
              done_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // load/start are ignored here; stop preempts a coincident tick
          if (stop) begin
            state <= ST_PAUSE;
          end else if (tick && !at_zero) begin
            if (last_step) begin
              done_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (rl_nonzero) begin
                ms_q  <= rl_ms;
                min_q <= rl_min;
              end else begin
                ms_q  <= '0;
                state <= ST_EXPIRED;
              end
`else
              ms_q  <= '0;
              state <= ST_EXPIRED;
`endif
            end else if (ms_q != '0) begin
              ms_q <= ms_q - 1'b1;
            end else begin
              ms_q  <= MS_TOP;
              min_q <= min_q - 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (load) begin
            ms_q  <= ld_ms;
            min_q <= load_min;
            state <= ST_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rl_ms  <= ld_ms;
            rl_min <= load_min;
`endif
          end else if (start && !stop) begin
            state <= ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if (load) begin
            ms_q  <= ld_ms;
            min_q <= load_min;
            state <= ST_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rl_ms  <= ld_ms;
            rl_min <= load_min;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign milicount = ms_q;
  assign mincount  = min_q;
  assign run_on    = (state == ST_RUN);
  assign pause_on  = (state == ST_PAUSE);
  assign expired   = (state == ST_EXPIRED);
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a
// randomized run compared against a total-count reference model.
module tb_countdown_timer;

  localparam int TD  = 4;
  localparam int MSM = 10;
  localparam int W   = 10;

  logic         clk = 1'b0;
  logic         reset, load, start, stop;
  logic [W-1:0] load_min, load_ms;
  logic [W-1:0] milicount, mincount;
  logic         run_on, pause_on, expired, done;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.TICK_DIV(TD), .MS_MAX(MSM), .CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_min  (load_min),
    .load_ms   (load_ms),
    .start     (start),
    .stop      (stop),
    .milicount (milicount),
    .mincount  (mincount),
    .run_on    (run_on),
    .pause_on  (pause_on),
    .expired   (expired),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference model: whole remaining time as one integer of ms steps,
  // plus the number of RUN cycles elapsed since the last tick.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} m_state_e;
  m_state_e m_st = M_IDLE;
  int m_total = 0, m_phase = 0, m_reload = 0;
  bit m_done = 0;

  function automatic int load_val(input logic [W-1:0] mn, input logic [W-1:0] ms);
    int c;
    c = (int'(ms) > MSM) ? MSM : int'(ms);
    return int'(mn) * (MSM + 1) + c;
  endfunction

  always @(posedge clk) begin
    m_done = 0;
    if (reset) begin
      m_st = M_IDLE; m_total = 0; m_phase = 0; m_reload = 0;
    end else begin
      case (m_st)
        M_IDLE:
          if (load) begin
            m_total = load_val(load_min, load_ms); m_reload = m_total;
          end else if (start && !stop) begin
            if (m_total == 0) begin m_st = M_EXP; m_done = 1; end
            else begin m_st = M_RUN; m_phase = 0; end
          end
        M_RUN:
          if (stop) m_st = M_PAUSE;
          else begin
            m_phase++;
            if (m_phase == TD) begin
              m_phase = 0;
              m_total--;
              if (m_total == 0) begin
                m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (m_reload != 0) m_total = m_reload;
                else m_st = M_EXP;
`else
                m_st = M_EXP;
`endif
              end
            end
          end
        M_PAUSE:
          if (load) begin
            m_total = load_val(load_min, load_ms); m_reload = m_total;
            m_st = M_IDLE; m_phase = 0;
          end else if (start && !stop) m_st = M_RUN;
        M_EXP:
          if (load) begin
            m_total = load_val(load_min, load_ms); m_reload = m_total;
            m_st = M_IDLE;
          end
        default: m_st = M_IDLE;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input int mn, input int ms);
    load = 1'b1; load_min = W'(mn); load_ms = W'(ms);
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*W+3:0] obs;
    reset = 1'b1; cyc(); reset = 1'b0;
    obs = {mincount, milicount, run_on, pause_on, expired, done};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_init got %h want 0", obs); end
    do_load(1, 3);
    do_start();
    cyc();
    checks++;
    if (!(run_on === 1'b1 && mincount === 10'd1 && milicount === 10'd3)) begin
      errors++; $display("FAIL reset_prerun got %0d:%0d run=%b want 1:3 run=1", mincount, milicount, run_on);
    end
    reset = 1'b1; cyc(); reset = 1'b0;
    obs = {mincount, milicount, run_on, pause_on, expired, done};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_midrun got %h want 0", obs); end
  endtask

`ifndef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_expire();
    do_load(0, 2);
    do_start();                       // edge N
    repeat (TD - 1) cyc();
    checks++;
    if (milicount !== 10'd2) begin errors++; $display("FAIL exp_early got %0d want 2", milicount); end
    cyc();                            // edge N+4
    checks++;
    if (!(milicount === 10'd1 && mincount === 10'd0 && run_on === 1'b1)) begin
      errors++; $display("FAIL exp_first got %0d:%0d run=%b want 0:1 run=1", mincount, milicount, run_on);
    end
    repeat (TD - 1) cyc();
    checks++;
    if (!(milicount === 10'd1 && expired === 1'b0)) begin
      errors++; $display("FAIL exp_mid got ms=%0d exp=%b want 1 0", milicount, expired);
    end
    cyc();                            // edge N+8
    checks++;
    if (!(milicount === 10'd0 && expired === 1'b1 && done === 1'b1 && run_on === 1'b0)) begin
      errors++; $display("FAIL exp_hit got ms=%0d exp=%b done=%b run=%b want 0 1 1 0", milicount, expired, done, run_on);
    end
    cyc();
    checks++;
    if (!(done === 1'b0 && expired === 1'b1)) begin
      errors++; $display("FAIL exp_hold got done=%b exp=%b want 0 1", done, expired);
    end
    do_start();
    checks++;
    if (!(done === 1'b0 && expired === 1'b1 && milicount === 10'd0)) begin
      errors++; $display("FAIL exp_start_ign got done=%b exp=%b ms=%0d want 0 1 0", done, expired, milicount);
    end
  endtask
`else
  task automatic test_auto_reload();
    do_load(0, 1);
    do_start();
    for (int k = 0; k < 3; k++) begin
      repeat (TD - 1) cyc();
      checks++;
      if (!(done === 1'b0 && run_on === 1'b1 && milicount === 10'd1)) begin
        errors++; $display("FAIL ar_between%0d got done=%b run=%b ms=%0d want 0 1 1", k, done, run_on, milicount);
      end
      cyc();
      checks++;
      if (!(done === 1'b1 && run_on === 1'b1 && expired === 1'b0 && milicount === 10'd1 && mincount === 10'd0)) begin
        errors++; $display("FAIL ar_pulse%0d got done=%b run=%b exp=%b %0d:%0d want 1 1 0 0:1", k, done, run_on, expired, mincount, milicount);
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask
`endif

  task automatic test_borrow();
    do_load(1, 0);
    do_start();
    repeat (TD) cyc();
    checks++;
    if (!(mincount === 10'd0 && milicount === 10'd10 && run_on === 1'b1)) begin
      errors++; $display("FAIL borrow got %0d:%0d run=%b want 0:10 run=1", mincount, milicount, run_on);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_pause();
    do_load(0, 5);
    do_start();                       // edge N
    cyc(); cyc();                     // two prescaler steps
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++;
    if (!(pause_on === 1'b1 && milicount === 10'd5)) begin
      errors++; $display("FAIL pause_enter got pause=%b ms=%0d want 1 5", pause_on, milicount);
    end
    repeat (20) cyc();
    checks++;
    if (!(pause_on === 1'b1 && milicount === 10'd5)) begin
      errors++; $display("FAIL pause_hold got pause=%b ms=%0d want 1 5", pause_on, milicount);
    end
    do_start();                       // edge R
    checks++;
    if (!(run_on === 1'b1 && milicount === 10'd5)) begin
      errors++; $display("FAIL resume got run=%b ms=%0d want 1 5", run_on, milicount);
    end
    cyc();
    checks++;
    if (milicount !== 10'd5) begin errors++; $display("FAIL resume_r1 got %0d want 5", milicount); end
    cyc();
    checks++;
    if (milicount !== 10'd4) begin errors++; $display("FAIL resume_r2 got %0d want 4", milicount); end
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    checks++;
    if (!(pause_on === 1'b1 && run_on === 1'b0)) begin
      errors++; $display("FAIL start_stop got pause=%b run=%b want 1 0", pause_on, run_on);
    end
  endtask

  task automatic test_clamp_ignore();
    do_load(0, 15);
    checks++;
    if (!(milicount === 10'd10 && mincount === 10'd0 && pause_on === 1'b0 && run_on === 1'b0)) begin
      errors++; $display("FAIL clamp got %0d:%0d pause=%b want 0:10 idle", mincount, milicount, pause_on);
    end
    do_start();
    do_load(2, 2);
    checks++;
    if (!(milicount === 10'd10 && mincount === 10'd0 && run_on === 1'b1)) begin
      errors++; $display("FAIL load_in_run got %0d:%0d run=%b want 0:10 run=1", mincount, milicount, run_on);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_start_zero();
    do_load(0, 0);
    do_start();
    checks++;
    if (!(expired === 1'b1 && done === 1'b1 && run_on === 1'b0)) begin
      errors++; $display("FAIL zero_start got exp=%b done=%b run=%b want 1 1 0", expired, done, run_on);
    end
    cyc();
    checks++;
    if (!(expired === 1'b1 && done === 1'b0)) begin
      errors++; $display("FAIL zero_hold got exp=%b done=%b want 1 0", expired, done);
    end
    do_load(0, 3);
    checks++;
    if (!(expired === 1'b0 && milicount === 10'd3 && run_on === 1'b0)) begin
      errors++; $display("FAIL exp_reload got exp=%b ms=%0d want 0 3", expired, milicount);
    end
  endtask

  task automatic test_random();
    logic [2*W+3:0] obs, exp_v;
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      exp_v = {W'(m_total / (MSM + 1)), W'(m_total % (MSM + 1)),
               m_st == M_RUN, m_st == M_PAUSE, m_st == M_EXP, m_done};
      obs = {mincount, milicount, run_on, pause_on, expired, done};
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL rand_cyc%0d got %h want %h", i, obs, exp_v);
      end
      reset    = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_min = W'($urandom_range(0, 2));
      load_ms  = W'($urandom_range(0, 15));
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 11) == 0);
      cyc();
    end
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
    load_min = '0; load_ms = '0;
    @(negedge clk);
    test_reset();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    test_expire();
`else
    test_auto_reload();
`endif
    test_borrow();
    test_pause();
    test_clamp_ignore();
    test_start_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
